smul_rr_sched: RTL and testbench



---
 rtl/smul_sched_pkg.sv | 32 +++
 rtl/smul_rr_sched_smul.sv | 16 +
 rtl/smul_rr_sched.sv | 131 +++++++++++++
 tb/tb_smul_rr_sched.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smul_sched_pkg.sv
// Shared widths and arbitration helpers for schedulers that time-share one
// signed multiplier among several requesters.
package smul_sched_pkg;

  localparam int MAX_REQ   = 32;
  localparam int MAX_IDX_W = 5;

  function automatic int PROD_W(input int width_a, input int width_b);
    return width_a + width_b - 1;
  endfunction

  function automatic int id_w(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

  // First set bit of valid at or above ptr, wrapping modulo num_req; -1 when none.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] valid, input int ptr,
                                 input int num_req);
    int pick;
    int j;
    pick = -1;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < num_req && pick < 0) begin
        j = ptr + i;
        if (j >= num_req) j = j - num_req;
        if (valid[j[MAX_IDX_W-1:0]]) pick = j;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/smul_rr_sched_smul.sv
// Signed multiplier shared by the scheduler; the product keeps
// WIDTH_A+WIDTH_B-1 bits, so only (-max)*(-max) wraps.
module SMUL
  import smul_sched_pkg::*;
#(
  parameter int WIDTH_A = 16,
  parameter int WIDTH_B = 16
) (
  input  logic signed [WIDTH_A-1:0]                 a,
  input  logic signed [WIDTH_B-1:0]                 b,
  output logic signed [PROD_W(WIDTH_A, WIDTH_B)-1:0] p
);

  assign p = PROD_W(WIDTH_A, WIDTH_B)'(a * b);

endmodule

// File: rtl/smul_rr_sched.sv
// Round-robin scheduler feeding NUM_REQ requesters into one PIPE-stage signed
// multiplier. Define SMUL_SCHED_FIXED_PRIO_EN for lowest-index-wins arbitration.
module smul_rr_sched
  import smul_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH_A = 16,
  parameter int WIDTH_B = 16,
  parameter int PIPE    = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ*WIDTH_A-1:0]           req_a,
  input  logic [NUM_REQ*WIDTH_B-1:0]           req_b,
  output logic                                 rsp_valid,
  input  logic                                 rsp_ready,
  output logic [PROD_W(WIDTH_A, WIDTH_B)-1:0]  rsp_data,
  output logic [id_w(NUM_REQ)-1:0]             rsp_id
);

  localparam int P_W  = PROD_W(WIDTH_A, WIDTH_B);
  localparam int ID_W = id_w(NUM_REQ);

  logic            adv;
  logic            xfer;
  int              pick;
  logic [ID_W-1:0] g_idx;

  assign adv = !(rsp_valid && !rsp_ready);

`ifdef SMUL_SCHED_FIXED_PRIO_EN
  assign pick = rr_pick(MAX_REQ'(req_valid), 0, NUM_REQ);
`else
  logic [ID_W-1:0] ptr;

  assign pick = rr_pick(MAX_REQ'(req_valid), int'(ptr), NUM_REQ);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= (g_idx == ID_W'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
    end
  end
`endif

  assign xfer  = adv && (pick >= 0);
  assign g_idx = ID_W'(pick);

  // NOTE: default assigned first so no path leaves req_ready unassigned (no latch).
  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[g_idx] = 1'b1;
  end

  logic                      s1_v;
  logic signed [WIDTH_A-1:0] s1_a;
  logic signed [WIDTH_B-1:0] s1_b;
  logic [ID_W-1:0]           s1_id;
  logic signed [P_W-1:0]     prod;

  // Operands and id only load on a real transfer; a bubble keeps the last pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v  <= 1'b0;
      s1_a  <= '0;
      s1_b  <= '0;
      s1_id <= '0;
    end else if (adv) begin
      s1_v <= xfer;
      if (xfer) begin
        s1_a  <= req_a[int'(g_idx)*WIDTH_A +: WIDTH_A];
        s1_b  <= req_b[int'(g_idx)*WIDTH_B +: WIDTH_B];
        s1_id <= g_idx;
      end
    end
  end

  SMUL #(
    .WIDTH_A(WIDTH_A),
    .WIDTH_B(WIDTH_B)
  ) u_smul (
    .a(s1_a),
    .b(s1_b),
    .p(prod)
  );

  generate
    if (PIPE == 1) begin : g_pipe1
      assign rsp_valid = s1_v;
      assign rsp_data  = prod;
      assign rsp_id    = s1_id;
    end else begin : g_pipen
      localparam int D = PIPE - 1;

      logic            v_q  [D];
      logic [P_W-1:0]  d_q  [D];
      logic [ID_W-1:0] id_q [D];

      // NOTE: these stage arrays are reset element by element because the
      // response outputs must read zero out of reset.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < D; k++) begin
            v_q[k]  <= 1'b0;
            d_q[k]  <= '0;
            id_q[k] <= '0;
          end
        end else if (adv) begin
          v_q[0]  <= s1_v;
          d_q[0]  <= prod;
          id_q[0] <= s1_id;
          for (int k = 1; k < D; k++) begin
            v_q[k]  <= v_q[k-1];
            d_q[k]  <= d_q[k-1];
            id_q[k] <= id_q[k-1];
          end
        end
      end

      assign rsp_valid = v_q[D-1];
      assign rsp_data  = d_q[D-1];
      assign rsp_id    = id_q[D-1];
    end
  endgenerate

endmodule

// File: tb/tb_smul_rr_sched.sv
// Self-checking bench for smul_rr_sched: directed scenarios plus random traffic
// scored against an in-order result queue with an advance-count latency model.
module tb_smul_rr_sched;

  localparam int N    = 4;
  localparam int WA   = 16;
  localparam int WB   = 16;
  localparam int PIPE = 2;
  localparam int PW   = WA + WB - 1;
  localparam int IDW  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*WA-1:0] req_a;
  logic [N*WB-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [PW-1:0]   rsp_data;
  logic [IDW-1:0]  rsp_id;

  always #5 clk = ~clk;

  smul_rr_sched #(
    .NUM_REQ(N), .WIDTH_A(WA), .WIDTH_B(WB), .PIPE(PIPE)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Stimulus for the next cycle
  logic [N-1:0]          vld;
  logic signed [WA-1:0]  opa [N];
  logic signed [WB-1:0]  opb [N];
  logic                  rdy;

  // Reference model: results leave in issue order once PIPE advancing cycles have passed
  typedef struct {
    logic [PW-1:0] data;
    int            id;
    longint        t;
  } item_t;

  item_t         q[$];
  int            m_ptr;
  longint        adv_cnt;
  logic [N-1:0]  e_ready;
  logic          e_rv;
  logic [PW-1:0] e_data;
  int            e_id;

  task automatic model_clear();
    q.delete();
    m_ptr   = 0;
    adv_cnt = 0;
  endtask

  task automatic model();
    int            g;
    int            c;
    int            start;
    logic          adv;
    logic signed [63:0] full;
    item_t         it;
    e_rv = 1'b0;
    if (q.size() > 0) e_rv = (adv_cnt - q[0].t) == longint'(PIPE);
    e_data = '0;
    e_id   = 0;
    if (e_rv) begin
      e_data = q[0].data;
      e_id   = q[0].id;
    end
    adv = !(e_rv && !rdy);
`ifdef SMUL_SCHED_FIXED_PRIO_EN
    start = 0;
`else
    start = m_ptr;
`endif
    g = -1;
    if (adv) begin
      for (int k = 0; k < N; k++) begin
        c = (start + k) % N;
        if (g < 0 && vld[c]) g = c;
      end
    end
    e_ready = '0;
    if (g >= 0) e_ready[g] = 1'b1;
    if (e_rv && rdy) void'(q.pop_front());
    if (g >= 0) begin
      full    = longint'(opa[g]) * longint'(opb[g]);
      it.data = full[PW-1:0];
      it.id   = g;
      it.t    = adv_cnt;
      q.push_back(it);
      m_ptr = (g + 1) % N;
    end
    if (adv) adv_cnt++;
  endtask

  task automatic apply();
    req_valid = vld;
    rsp_ready = rdy;
    for (int i = 0; i < N; i++) begin
      req_a[i*WA +: WA] = opa[i];
      req_b[i*WB +: WB] = opb[i];
    end
  endtask

  // Drive at the falling edge, let combinational paths settle, then predict.
  task automatic step();
    @(negedge clk);
    apply();
    #1;
    model();
    cyc++;
  endtask

  function automatic logic [15:0] rand_op();
    logic [15:0] corners [4];
    corners[0] = 16'h8000;
    corners[1] = 16'h7fff;
    corners[2] = 16'h0000;
    corners[3] = 16'hffff;
    if ($urandom_range(7) == 0) return corners[$urandom_range(3)];
    return 16'($urandom);
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      opa[i] = rand_op();
      opb[i] = rand_op();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    vld = '0;
    rdy = 1'b1;
    apply();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    vld = '0;
    rdy = 1'b1;
    apply();
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++;
    if (rsp_data !== '0) begin n_fail++; $display("FAIL reset_rsp_data: got %0h want 0", rsp_data); end
    n_checks++;
    if (rsp_id !== '0) begin n_fail++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
    n_checks++;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_idle_ready: got %b want 0000", req_ready); end
    vld = 4'b0100;
    apply();
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL reset_grant: got %b want 0100", req_ready); end
    @(negedge clk);
    vld = '0;
    apply();
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_single();
    logic [PW-1:0] want;
    want = -15;
    do_reset();
    vld = '0;
    step();
    n_checks++;
    if (rsp_data !== '0) begin n_fail++; $display("FAIL idle_rsp_data: got %0h want 0", rsp_data); end
    vld    = 4'b0001;
    opa[0] = 16'sd3;
    opb[0] = -16'sd5;
    step();
    n_checks++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b want 0001", req_ready); end
    vld = '0;
    for (int k = 1; k <= PIPE; k++) begin
      step();
      n_checks++;
      if (rsp_valid !== (k == PIPE)) begin
        n_fail++; $display("FAIL single_latency k=%0d: got %b want %b", k, rsp_valid, k == PIPE);
      end
      if (k == PIPE) begin
        n_checks++;
        if (rsp_data !== want || rsp_id !== 2'd0) begin
          n_fail++; $display("FAIL single_result: got %0d id %0d want -15 id 0", $signed(rsp_data), rsp_id);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int           exp_g;
    int           exp_id;
    logic [N-1:0] eg;
    do_reset();
    vld = '1;
    rdy = 1'b1;
    for (int k = 0; k < 12; k++) begin
      rand_ops();
      step();
`ifdef SMUL_SCHED_FIXED_PRIO_EN
      exp_g  = 0;
      exp_id = 0;
`else
      exp_g  = k % N;
      exp_id = (k - PIPE + N) % N;
`endif
      eg = '0;
      eg[exp_g] = 1'b1;
      n_checks++;
      if (req_ready !== eg) begin n_fail++; $display("FAIL rr_grant k=%0d: got %b want %b", k, req_ready, eg); end
      if (k >= PIPE) begin
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== exp_id[IDW-1:0] || rsp_data !== e_data) begin
          n_fail++;
          $display("FAIL rr_rsp k=%0d: got v%b id %0d data %0h want v1 id %0d data %0h",
                   k, rsp_valid, rsp_id, rsp_data, exp_id, e_data);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    rdy = 1'b1;
    vld = 4'b1010;
    for (int k = 0; k < 2; k++) begin
      rand_ops();
      step();
      n_checks++;
      if (req_ready !== e_ready) begin n_fail++; $display("FAIL bp_issue k=%0d: got %b want %b", k, req_ready, e_ready); end
    end
    vld = '1;
    rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rand_ops();
      step();
      n_checks++;
      if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready k=%0d: got %b want 0000", k, req_ready); end
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== e_data || rsp_id !== e_id[IDW-1:0]) begin
        n_fail++;
        $display("FAIL bp_hold k=%0d: got v%b id %0d data %0h want v1 id %0d data %0h",
                 k, rsp_valid, rsp_id, rsp_data, e_id, e_data);
      end
    end
    rdy = 1'b1;
    for (int k = 0; k < 6 + PIPE + 2; k++) begin
      vld = (k < 6) ? 4'b1111 : 4'b0000;
      rand_ops();
      step();
      n_checks++;
      if (req_ready !== e_ready || rsp_valid !== e_rv ||
          (e_rv && (rsp_data !== e_data || rsp_id !== e_id[IDW-1:0]))) begin
        n_fail++;
        $display("FAIL bp_release k=%0d: got rdy %b v%b id %0d data %0h want rdy %b v%b id %0d data %0h",
                 k, req_ready, rsp_valid, rsp_id, rsp_data, e_ready, e_rv, e_id, e_data);
      end
    end
  endtask

  task automatic test_overflow();
    logic [PW-1:0] want_min;
    logic [PW-1:0] want_mix;
    want_min = -1073741824;
    want_mix = -1073709056;
    do_reset();
    rdy = 1'b1;
    for (int k = 0; k <= PIPE + 1; k++) begin
      vld = (k == 0) ? 4'b0100 : (k == 1) ? 4'b0010 : 4'b0000;
      opa[2] = -16'sd32768; opb[2] = -16'sd32768;
      opa[1] =  16'sd32767; opb[1] = -16'sd32768;
      step();
      if (k == PIPE) begin
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== want_min || rsp_id !== 2'd2) begin
          n_fail++; $display("FAIL ovf_min: got v%b %0d id %0d want v1 -1073741824 id 2", rsp_valid, $signed(rsp_data), rsp_id);
        end
      end
      if (k == PIPE + 1) begin
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== want_mix || rsp_id !== 2'd1) begin
          n_fail++; $display("FAIL ovf_mix: got v%b %0d id %0d want v1 -1073709056 id 1", rsp_valid, $signed(rsp_data), rsp_id);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [PW-1:0] want2;
    logic [PW-1:0] want3;
    want2 = -63;
    want3 = -143;
    do_reset();
    rdy = 1'b1;
    opa[2] = 16'sd7;   opb[2] = -16'sd9;
    opa[3] = -16'sd11; opb[3] = 16'sd13;
    for (int k = 0; k <= PIPE + 2; k++) begin
      vld = (k == 0) ? 4'b0100 : (k == 1) ? 4'b1000 : 4'b0000;
      step();
      if (k < 2) begin
        n_checks++;
        if (req_ready !== vld) begin n_fail++; $display("FAIL b2b_grant k=%0d: got %b want %b", k, req_ready, vld); end
      end
      n_checks++;
      if (rsp_valid !== (k == PIPE || k == PIPE + 1)) begin
        n_fail++; $display("FAIL b2b_valid k=%0d: got %b want %b", k, rsp_valid, k == PIPE || k == PIPE + 1);
      end
      if (k == PIPE) begin
        n_checks++;
        if (rsp_data !== want2 || rsp_id !== 2'd2) begin
          n_fail++; $display("FAIL b2b_first: got %0d id %0d want -63 id 2", $signed(rsp_data), rsp_id);
        end
      end
      if (k == PIPE + 1) begin
        n_checks++;
        if (rsp_data !== want3 || rsp_id !== 2'd3) begin
          n_fail++; $display("FAIL b2b_second: got %0d id %0d want -143 id 3", $signed(rsp_data), rsp_id);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    rdy = 1'b1;
    vld = 4'b0001; rand_ops(); step();
    vld = 4'b0010; rand_ops(); step();
    vld = 4'b0000; step();
    n_checks++;
    if (rsp_valid !== e_rv) begin n_fail++; $display("FAIL mid_pre: got %b want %b", rsp_valid, e_rv); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async: got %b want 0", rsp_valid); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    for (int k = 0; k < 6; k++) begin
      step();
      n_checks++;
      if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale k=%0d: got %b want 0", k, rsp_valid); end
    end
    vld = '1;
    rand_ops();
    step();
    n_checks++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_first_grant: got %b want 0001", req_ready); end
    vld = '0;
    for (int k = 0; k < PIPE + 1; k++) begin
      step();
      n_checks++;
      if (rsp_valid !== e_rv || (e_rv && (rsp_data !== e_data || rsp_id !== e_id[IDW-1:0]))) begin
        n_fail++; $display("FAIL mid_drain k=%0d: got v%b id %0d data %0h want v%b id %0d data %0h",
                           k, rsp_valid, rsp_id, rsp_data, e_rv, e_id, e_data);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      if (k < 590) begin
        vld = N'($urandom);
        rdy = ($urandom_range(3) != 0);
      end else begin
        vld = '0;
        rdy = 1'b1;
      end
      rand_ops();
      step();
      n_checks++;
      if (req_ready !== e_ready || rsp_valid !== e_rv ||
          (e_rv && (rsp_data !== e_data || rsp_id !== e_id[IDW-1:0]))) begin
        n_fail++;
        $display("FAIL random cyc=%0d: got rdy %b v%b id %0d data %0h want rdy %b v%b id %0d data %0h",
                 cyc, req_ready, rsp_valid, rsp_id, rsp_data, e_ready, e_rv, e_id, e_data);
      end
    end
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    vld = '0;
    rdy = 1'b1;
    for (int i = 0; i < N; i++) begin
      opa[i] = '0;
      opb[i] = '0;
    end
    apply();
    model_clear();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
